prbs_checker: RTL

- Serial PRBS error checker that consumes the bit stream produced by the project's LFSR pattern generator, typically after a channel or error-injection stage.
- Self-synchronises a local LFSR model (same N/TAPS) to the incoming stream, then flags mismatches as bit errors.
- Maintains saturating bit and error counters for BER measurement, and a lock indicator with loss-of-lock detection.

---
 rtl/prbs_checker.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronises a local LFSR to the stream,
// then flywheels it to count bit errors and detect loss of lock.
module prbs_checker #(
  parameter int unsigned N        = 3,
  parameter logic [1:N]  TAPS     = 3'b011,
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned WIN      = 32,
  parameter int unsigned LOSS_THR = 4,
  parameter int unsigned CW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          in_bit,
  input  logic          clear,
  output logic          locked,
  output logic          err_pulse,
  output logic [CW-1:0] bit_count,
  output logic [CW-1:0] err_count
);

  localparam int FW = $clog2(N + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int EW = $clog2(LOSS_THR + 1);

  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    FILL,
    CHECK,
    LOCKED
  } state_e;

  state_e        state_q, state_d;
  logic [1:N]    s_q, s_d;
  logic [FW-1:0] fill_cnt_q, fill_cnt_d;
  logic [MW-1:0] match_cnt_q, match_cnt_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [EW-1:0] win_err_q, win_err_d;
  logic          err_pulse_q, err_pulse_d;
  logic [CW-1:0] bit_count_q, bit_count_d;
  logic [CW-1:0] err_count_q, err_count_d;

  logic          p;
  logic          mism;
  logic          s_zero;
  logic [1:N]    s_rx;
  logic [1:N]    s_fly;
  logic [EW-1:0] win_err_nx;
  logic          bit_inc;
  logic          err_inc;

  assign p      = ^(s_q & TAPS);
  assign mism   = (in_bit != p);
  assign s_zero = (s_q == '0);

  // Shift toward higher indices; s[1] always holds the newest bit.
  always_comb begin
    s_rx     = s_q >> 1;
    s_rx[1]  = in_bit;
    s_fly    = s_q >> 1;
    s_fly[1] = p;
  end

  assign win_err_nx = win_err_q + EW'(mism);

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_pulse_d = 1'b0;
    bit_inc     = 1'b0;
    err_inc     = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        FILL: begin
          s_d = s_rx;
          if (fill_cnt_q == FW'(N - 1)) begin
            state_d     = CHECK;
            fill_cnt_d  = '0;
            match_cnt_d = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + FW'(1);
          end
        end
        CHECK: begin
          s_d = s_rx;
          // An all-zero model never counts as a match.
          if (!mism && !s_zero) begin
            if (match_cnt_q == MW'(LOCK_CNT - 1)) begin
              state_d     = LOCKED;
              match_cnt_d = '0;
              win_cnt_d   = '0;
              win_err_d   = '0;
            end else begin
              match_cnt_d = match_cnt_q + MW'(1);
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          s_d         = s_fly;
          bit_inc     = 1'b1;
          err_inc     = mism;
          err_pulse_d = mism;
          if (win_err_nx >= EW'(LOSS_THR)) begin
            state_d    = FILL;
            fill_cnt_d = '0;
          end else if (win_cnt_q == WW'(WIN - 1)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WW'(1);
            win_err_d = win_err_nx;
          end
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  always_comb begin
    bit_count_d = bit_count_q;
    err_count_d = err_count_q;
    if (clear) begin
      bit_count_d = '0;
      err_count_d = '0;
    end else begin
      if (bit_inc && (bit_count_q != CNT_MAX)) begin
        bit_count_d = bit_count_q + CW'(1);
      end
      if (err_inc && (err_count_q != CNT_MAX)) begin
        err_count_d = err_count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      s_q         <= '0;
      fill_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_pulse_q <= 1'b0;
      bit_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_pulse_q <= err_pulse_d;
      bit_count_q <= bit_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign bit_count = bit_count_q;
  assign err_count = err_count_q;

endmodule
